// File: rtl/num_row_fmt_pkg.sv
// rtl/num_row_fmt_pkg.sv - shared display constants, state encoding and helpers for the row formatter
package num_row_fmt_pkg;

    localparam int NUM_PAGES  = 4;
    localparam int NUM_COLS   = 16;
    localparam int ROW_W      = $clog2(NUM_PAGES);
    localparam int COL_W      = $clog2(NUM_COLS);
    localparam int NUM_DIGITS = 5;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    localparam logic [7:0] ASCII_BLANK = 8'h20;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SHIFT  = 3'd2;
    localparam logic [2:0] S_EMIT   = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    typedef logic [BCD_W-1:0] bcd_t;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/num_row_fmt_if.sv
// rtl/num_row_fmt_if.sv - request and character-write bundle between a client and the row formatter
interface num_row_fmt_if;
    import num_row_fmt_pkg::*;

    logic             START;
    logic [15:0]      VALUE;
    logic [ROW_W-1:0] ROW;
    logic             BUSY;
    logic             WR_EN;
    logic [ROW_W-1:0] WR_ROW;
    logic [COL_W-1:0] WR_COL;
    logic [7:0]       WR_CHAR;
    logic             DONE;

    modport master (
        output START, VALUE, ROW,
        input  BUSY, WR_EN, WR_ROW, WR_COL, WR_CHAR, DONE
    );

    modport slave (
        input  START, VALUE, ROW,
        output BUSY, WR_EN, WR_ROW, WR_COL, WR_CHAR, DONE
    );

endinterface

// File: rtl/num_row_fmt_bin2bcd_step.sv
// rtl/num_row_fmt_bin2bcd_step.sv - one combinational double-dabble step: add-3 correction then shift in one bit
module bin2bcd_step
    import num_row_fmt_pkg::*;
(
    input  bcd_t i_bcd,
    input  logic i_bit,
    output bcd_t o_bcd
);

    bcd_t w_adj;

    always_comb begin
        w_adj = i_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i_bcd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = i_bcd[4*i +: 4] + 4'd3;
        end
    end

    // The top nibble never exceeds 6 for a 16-bit magnitude, so its carry-out is never needed
    assign o_bcd = {w_adj[BCD_W-2:0], i_bit};

endmodule

// File: rtl/num_row_fmt.sv
// rtl/num_row_fmt.sv - formats a signed 16-bit value right-aligned into one 16-column screen page
module num_row_fmt
    import num_row_fmt_pkg::*;
#(
    parameter logic [7:0] BLANK_CHAR = ASCII_BLANK,
    parameter logic [7:0] NEG_CHAR   = ASCII_MINUS
)(
    input  logic               CLK,
    input  logic               RST,
    num_row_fmt_if.slave       bus
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

    logic [2:0]       r_state;
    logic [15:0]      r_value;
    logic [ROW_W-1:0] r_row;
    logic             r_sign;
    logic [15:0]      r_mag;
    bcd_t             r_bcd;
    logic [3:0]       r_cnt;
    logic             r_busy;
    logic             r_wr_en;
    logic [ROW_W-1:0] r_wr_row;
    logic [COL_W-1:0] r_wr_col;
    logic [7:0]       r_wr_char;
    logic             r_done;

    bcd_t             w_bcd_next;
    logic [2:0]       w_msd;
    logic [COL_W-1:0] w_col_next;
    logic [3:0]       w_idx;
    logic [3:0]       w_digit;
    logic [7:0]       w_char;

    bin2bcd_step u_step (
        .i_bcd (r_bcd),
        .i_bit (r_mag[15]),
        .o_bcd (w_bcd_next)
    );

    // Most significant non-zero digit; digit 0 is always shown so an all-zero value prints '0'
    always_comb begin
        w_msd = 3'd0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0)
                w_msd = 3'(i);
        end
    end

    assign w_col_next = r_wr_col + 1'b1;
    assign w_idx      = LAST_COL - w_col_next;

    always_comb begin
        case (w_idx)
            4'd0:    w_digit = r_bcd[3:0];
            4'd1:    w_digit = r_bcd[7:4];
            4'd2:    w_digit = r_bcd[11:8];
            4'd3:    w_digit = r_bcd[15:12];
            default: w_digit = r_bcd[19:16];
        endcase
    end

    always_comb begin
        w_char = BLANK_CHAR;
        if (w_col_next >= 4'd11 && w_idx <= {1'b0, w_msd})
            w_char = digit_char(w_digit);
        else if (r_sign && w_col_next == 4'd14 - {1'b0, w_msd})
            w_char = NEG_CHAR;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_value   <= '0;
            r_row     <= '0;
            r_sign    <= 1'b0;
            r_mag     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_row  <= '0;
            r_wr_col  <= '0;
            r_wr_char <= 8'h00;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.START) begin
                        r_value <= bus.VALUE;
                        r_row   <= bus.ROW;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_sign  <= r_value[15];
                    r_mag   <= r_value[15] ? (~r_value + 16'd1) : r_value;
                    r_bcd   <= '0;
                    r_cnt   <= '0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_bcd <= w_bcd_next;
                    r_mag <= {r_mag[14:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    // Column 0 is always blank, so it can go out on the same edge as the final shift
                    if (r_cnt == 4'd15) begin
                        r_wr_en   <= 1'b1;
                        r_wr_row  <= r_row;
                        r_wr_col  <= '0;
                        r_wr_char <= BLANK_CHAR;
                        r_state   <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    r_wr_col  <= w_col_next;
                    r_wr_char <= w_char;
                    if (w_col_next == LAST_COL)
                        r_state <= S_FINISH;
                end
                S_FINISH: begin
                    r_wr_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.BUSY    = r_busy;
    assign bus.WR_EN   = r_wr_en;
    assign bus.WR_ROW  = r_wr_row;
    assign bus.WR_COL  = r_wr_col;
    assign bus.WR_CHAR = r_wr_char;
    assign bus.DONE    = r_done;

endmodule
